// File: rtl/nios_system_com_nios_mul_pkg.sv
// Shared definitions for the Nios II M-stage multiply unit.
//   - mul_mode_e : the four multiply opcodes carried on in_mode
//   - LIMB_W     : operand limb width fed to each partial-product cell
//   - PP_W       : width of one 17x17 signed partial product
//   - limb_count : number of limbs per operand for a given WIDTH
//   - width_ok / latency_ok : legality checks evaluated at elaboration
//   - src1_signed / src2_signed : operand signedness for an opcode
package nios_system_com_nios_mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,  // low half, sign-independent
    MULXUU = 2'b01,  // high half, unsigned x unsigned
    MULXSU = 2'b10,  // high half, signed x unsigned
    MULXSS = 2'b11   // high half, signed x signed
  } mul_mode_e;

  localparam int LIMB_W = 16;
  localparam int PP_W   = 2 * (LIMB_W + 1);

  function automatic int limb_count(input int width);
    return width / LIMB_W;
  endfunction

  function automatic bit width_ok(input int width);
    return (width == 16) || (width == 32) || (width == 64);
  endfunction

  function automatic bit latency_ok(input int latency);
    return (latency >= 2) && (latency <= 4);
  endfunction

  function automatic bit src1_signed(input logic [1:0] mode);
    return (mode == MULXSU) || (mode == MULXSS);
  endfunction

  function automatic bit src2_signed(input logic [1:0] mode);
    return (mode == MULXSS);
  endfunction

endpackage

// File: rtl/nios_system_com_nios_mul_pp17.sv
// Registered 17x17 signed multiplier cell; one instance per limb pair.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears the product register
//   i_en - load enable (pipeline advance)
//   i_a  - 17-bit signed limb of the multiplicand
//   i_b  - 17-bit signed limb of the multiplier
//   o_p  - registered 34-bit signed product
module nios_system_com_nios_mul_pp17
  import nios_system_com_nios_mul_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic signed [LIMB_W:0]   i_a,
  input  logic signed [LIMB_W:0]   i_b,
  output logic signed [PP_W-1:0]   o_p
);

  logic signed [PP_W-1:0] r_p;

  // Operands are widened to the full product width before multiplying so
  // the result is exact and the shape matches a hard DSP multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= PP_W'(i_a) * PP_W'(i_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/nios_system_com_nios_mul_unit.sv
// Pipelined integer multiply unit for the Nios II M-stage.
// Computes the 2*WIDTH-bit product of in_src1 and in_src2 and returns the
// low half (MUL) or the high half (MULXUU/MULXSU/MULXSS). The pipeline has
// LATENCY register stages that advance together; a stalled output freezes
// every stage.
// Stage 1     : limb partial products (pp17 cells)
// Stage 2     : row sums (LATENCY>=3) or full sum + half select (LATENCY=2)
// Stage 3     : full sum + half select (LATENCY>=3)
// Stages 4..L : result delay registers
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   in_valid / in_ready      - input handshake
//   in_src1, in_src2         - operands (WIDTH bits)
//   in_mode                  - opcode (mul_mode_e)
//   in_tag                   - opaque tag returned with the result
//   out_valid / out_ready    - output handshake
//   out_result, out_tag      - selected product half and its tag
module nios_system_com_nios_mul_unit
  import nios_system_com_nios_mul_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_src1,
  input  logic [WIDTH-1:0]  in_src2,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NL        = limb_count(WIDTH);
  localparam int NPP       = NL * NL;
  localparam int PW        = 2 * WIDTH;
  localparam int RES_STAGE = (LATENCY >= 3) ? 3 : 2;

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("nios_system_com_nios_mul_unit: WIDTH must be 16, 32 or 64");
    end
    if (!latency_ok(LATENCY)) begin : g_bad_latency
      $error("nios_system_com_nios_mul_unit: LATENCY must be 2..4");
    end
  endgenerate

  logic                     w_advance;
  logic                     w_src1_signed;
  logic                     w_src2_signed;
  logic signed [LIMB_W:0]   w_a_limb [NL];
  logic signed [LIMB_W:0]   w_b_limb [NL];
  logic signed [PP_W-1:0]   w_pp     [NPP];
  logic [PW-1:0]            w_row    [NL];
  logic [PW-1:0]            w_prod;
  logic [1:0]               w_sel_mode;
  logic [WIDTH-1:0]         w_result;

  logic [LATENCY:1]         r_valid;
  logic [1:0]               r_mode [1:RES_STAGE-1];
  logic [TAG_W-1:0]         r_tag  [1:LATENCY];
  logic [WIDTH-1:0]         r_res  [RES_STAGE:LATENCY];

  // The whole pipe moves or holds as one; only a stalled valid result
  // blocks it, so in_ready depends combinationally on out_ready.
  assign w_advance = ~r_valid[LATENCY] | out_ready;
  assign in_ready  = w_advance;

  assign w_src1_signed = src1_signed(in_mode);
  assign w_src2_signed = src2_signed(in_mode);

  // Limb split. Only the top limb of a signed operand carries its sign into
  // the 17th bit; every other limb is a plain unsigned 16-bit value.
  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_limb
      if (gi == NL - 1) begin : g_top
        assign w_a_limb[gi] = {w_src1_signed & in_src1[WIDTH-1], in_src1[gi*LIMB_W +: LIMB_W]};
        assign w_b_limb[gi] = {w_src2_signed & in_src2[WIDTH-1], in_src2[gi*LIMB_W +: LIMB_W]};
      end else begin : g_low
        assign w_a_limb[gi] = {1'b0, in_src1[gi*LIMB_W +: LIMB_W]};
        assign w_b_limb[gi] = {1'b0, in_src2[gi*LIMB_W +: LIMB_W]};
      end
    end

    // Partial product gi pairs src1 limb gi/NL with src2 limb gi%NL; its
    // weight is 2^(16*(gi/NL + gi%NL)).
    for (gi = 0; gi < NPP; gi++) begin : g_pp
      nios_system_com_nios_mul_pp17 u_pp (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_advance),
        .i_a  (w_a_limb[gi / NL]),
        .i_b  (w_b_limb[gi % NL]),
        .o_p  (w_pp[gi])
      );
    end
  endgenerate

  // Row i collects the products of src1 limb i with every src2 limb. Each
  // product is sign-extended to the full width; arithmetic is modulo 2^PW,
  // which is exact because the true product always fits in PW bits.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      w_row[i] = '0;
      for (int j = 0; j < NL; j++) begin
        w_row[i] = w_row[i] + (PW'(w_pp[i*NL + j]) << (LIMB_W * j));
      end
    end
  end

  generate
    if (LATENCY >= 3) begin : g_split
      // Row sums get their own register stage to shorten the adder path.
      logic [PW-1:0] r_row [NL];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NL; i++) begin
            r_row[i] <= '0;
          end
        end else if (w_advance) begin
          for (int i = 0; i < NL; i++) begin
            r_row[i] <= w_row[i];
          end
        end
      end

      always_comb begin
        w_prod = '0;
        for (int i = 0; i < NL; i++) begin
          w_prod = w_prod + (r_row[i] << (LIMB_W * i));
        end
      end

      assign w_sel_mode = r_mode[2];
    end else begin : g_flat
      always_comb begin
        w_prod = '0;
        for (int i = 0; i < NL; i++) begin
          w_prod = w_prod + (w_row[i] << (LIMB_W * i));
        end
      end

      assign w_sel_mode = r_mode[1];
    end
  endgenerate

  assign w_result = (w_sel_mode == MUL_LO) ? w_prod[WIDTH-1:0] : w_prod[PW-1:WIDTH];

  // Control/metadata shift register plus the result delay line. Bubbles
  // travel with the data (valid=0) and are never squeezed out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int k = 1; k < RES_STAGE; k++) begin
        r_mode[k] <= MUL_LO;
      end
      for (int k = 1; k <= LATENCY; k++) begin
        r_tag[k] <= '0;
      end
      for (int k = RES_STAGE; k <= LATENCY; k++) begin
        r_res[k] <= '0;
      end
    end else if (w_advance) begin
      r_valid   <= {r_valid[LATENCY-1:1], in_valid};
      r_mode[1] <= in_mode;
      for (int k = 2; k < RES_STAGE; k++) begin
        r_mode[k] <= r_mode[k-1];
      end
      r_tag[1] <= in_tag;
      for (int k = 2; k <= LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      r_res[RES_STAGE] <= w_result;
      for (int k = RES_STAGE + 1; k <= LATENCY; k++) begin
        r_res[k] <= r_res[k-1];
      end
    end
  end

  assign out_valid  = r_valid[LATENCY];
  assign out_result = r_res[LATENCY];
  assign out_tag    = r_tag[LATENCY];

endmodule

// File: tb/tb_nios_system_com_nios_mul_unit.sv
module tb_nios_system_com_nios_mul_unit;

  localparam int SW_OPS = 50;

  logic        clk;
  logic        reset;

  // Main instance: WIDTH=32, LATENCY=3
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  // Sweep instances: 0 W16/L2, 1 W16/L4, 2 W64/L2, 3 W64/L4
  logic        sw_in_valid  [4];
  logic        sw_in_ready  [4];
  logic [63:0] sw_src1      [4];
  logic [63:0] sw_src2      [4];
  logic [1:0]  sw_mode      [4];
  logic [4:0]  sw_tag       [4];
  logic        sw_out_valid [4];
  logic        sw_out_ready [4];
  logic [4:0]  sw_out_tag   [4];
  logic [15:0] sw_res16     [2];
  logic [63:0] sw_res64     [2];

  int n_total;
  int n_pass;

  nios_system_com_nios_mul_unit #(.WIDTH(32), .LATENCY(3), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  nios_system_com_nios_mul_unit #(.WIDTH(16), .LATENCY(2), .TAG_W(5)) dut_w16_l2 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
    .in_src1(sw_src1[0][15:0]), .in_src2(sw_src2[0][15:0]), .in_mode(sw_mode[0]), .in_tag(sw_tag[0]),
    .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready[0]),
    .out_result(sw_res16[0]), .out_tag(sw_out_tag[0])
  );

  nios_system_com_nios_mul_unit #(.WIDTH(16), .LATENCY(4), .TAG_W(5)) dut_w16_l4 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
    .in_src1(sw_src1[1][15:0]), .in_src2(sw_src2[1][15:0]), .in_mode(sw_mode[1]), .in_tag(sw_tag[1]),
    .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready[1]),
    .out_result(sw_res16[1]), .out_tag(sw_out_tag[1])
  );

  nios_system_com_nios_mul_unit #(.WIDTH(64), .LATENCY(2), .TAG_W(5)) dut_w64_l2 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
    .in_src1(sw_src1[2]), .in_src2(sw_src2[2]), .in_mode(sw_mode[2]), .in_tag(sw_tag[2]),
    .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready[2]),
    .out_result(sw_res64[0]), .out_tag(sw_out_tag[2])
  );

  nios_system_com_nios_mul_unit #(.WIDTH(64), .LATENCY(4), .TAG_W(5)) dut_w64_l4 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[3]), .in_ready(sw_in_ready[3]),
    .in_src1(sw_src1[3]), .in_src2(sw_src2[3]), .in_mode(sw_mode[3]), .in_tag(sw_tag[3]),
    .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready[3]),
    .out_result(sw_res64[1]), .out_tag(sw_out_tag[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: widen each operand to 128 bits with the opcode's signedness
  // and take the requested half of the exact product.
  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic [1:0] mode);
    logic [127:0] mask, ea, eb, p;
    mask = (128'd1 << w) - 128'd1;
    ea = {64'd0, a} & mask;
    eb = {64'd0, b} & mask;
    if (mode[1] && ea[w-1]) ea = ea | ~mask;
    if ((mode == 2'b11) && eb[w-1]) eb = eb | ~mask;
    p = ea * eb;
    if (mode == 2'b00) return 64'(p & mask);
    return 64'((p >> w) & mask);
  endfunction

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_8000;
      3:       v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Drives one op into the main instance with out_ready=1 and reports the
  // result, its tag and the number of cycles from acceptance to out_valid.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                       input logic [4:0] tag, output logic [31:0] res,
                       output logic [4:0] tg, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_src1   = a;
    in_src2   = b;
    in_mode   = mode;
    in_tag    = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    tg  = out_tag;
    $display("op a=%h b=%h mode=%0d tag=%0d -> result=%h tag=%0d after %0d cycles",
             a, b, mode, tag, res, tg, lat);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_src1   = '0;
    in_src2   = '0;
    in_mode   = 2'b00;
    in_tag    = '0;
    out_ready = 1'b0;
    for (int d = 0; d < 4; d++) begin
      sw_in_valid[d]  = 1'b0;
      sw_src1[d]      = '0;
      sw_src2[d]      = '0;
      sw_mode[d]      = 2'b00;
      sw_tag[d]       = '0;
      sw_out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (out_result !== 32'd0) $display("FAIL reset_out_result: got %h expected 0", out_result); else n_pass++;
    n_total++; if (out_tag !== 5'd0) $display("FAIL reset_out_tag: got %h expected 0", out_tag); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_latency();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    do_op(32'h0001_0003, 32'h0002_0005, 2'b00, 5'd7, res, tg, lat);
    n_total++; if (lat != 3) $display("FAIL mul_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (res !== 32'h000B_000F) $display("FAIL mul_result: got %h expected 000b000f", res); else n_pass++;
    n_total++; if (tg !== 5'd7) $display("FAIL mul_tag: got %0d expected 7", tg); else n_pass++;
    do_op(32'h0001_0003, 32'h0002_0005, 2'b01, 5'd8, res, tg, lat);
    n_total++; if (lat != 3) $display("FAIL mulxuu_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (res !== 32'h0000_0002) $display("FAIL mulxuu_result: got %h expected 00000002", res); else n_pass++;
    n_total++; if (tg !== 5'd8) $display("FAIL mulxuu_tag: got %0d expected 8", tg); else n_pass++;
  endtask

  task automatic test_all_ones();
    logic [31:0] exp_r [4];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    exp_r[0] = 32'h0000_0001;  // MUL
    exp_r[1] = 32'hFFFF_FFFE;  // MULXUU
    exp_r[2] = 32'hFFFF_FFFF;  // MULXSU
    exp_r[3] = 32'h0000_0000;  // MULXSS
    for (int m = 0; m < 4; m++) begin
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'(m), 5'(m + 1), res, tg, lat);
      n_total++;
      if (res !== exp_r[m] || tg !== 5'(m + 1))
        $display("FAIL ones_mode%0d: got %h tag %0d expected %h tag %0d", m, res, tg, exp_r[m], m + 1);
      else n_pass++;
    end
  endtask

  task automatic test_min_neg();
    logic [31:0] exp_r [4];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    exp_r[1] = 32'h4000_0000;  // MULXUU
    exp_r[2] = 32'hC000_0000;  // MULXSU
    exp_r[3] = 32'h4000_0000;  // MULXSS
    for (int m = 1; m < 4; m++) begin
      do_op(32'h8000_0000, 32'h8000_0000, 2'(m), 5'(m + 16), res, tg, lat);
      n_total++;
      if (res !== exp_r[m] || tg !== 5'(m + 16))
        $display("FAIL min_mode%0d: got %h tag %0d expected %h tag %0d", m, res, tg, exp_r[m], m + 16);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [4];
    int k;
    int got;
    int stall_left;
    bit stall_done;
    exp_r[0] = 32'h0000_3000;  // 0x1000 * 3
    exp_r[1] = 32'h0000_4004;  // 0x1001 * 4
    exp_r[2] = 32'h0000_500A;  // 0x1002 * 5
    exp_r[3] = 32'h0000_6012;  // 0x1003 * 6
    k = 0; got = 0; stall_left = 0; stall_done = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid && !stall_done) begin
        stall_done = 1;
        stall_left = 2;
      end
      out_ready = (stall_left == 0);
      in_valid  = (k < 4);
      in_src1   = 32'h1000 + 32'(k);
      in_src2   = 32'(3 + k);
      in_mode   = 2'b00;
      in_tag    = 5'(k);
      #1;
      if (stall_left > 0) begin
        n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid: got %b expected 1", out_valid); else n_pass++;
        n_total++; if (out_result !== exp_r[0]) $display("FAIL stall_hold_result: got %h expected %h", out_result, exp_r[0]); else n_pass++;
        n_total++; if (out_tag !== 5'd0) $display("FAIL stall_hold_tag: got %0d expected 0", out_tag); else n_pass++;
        stall_left--;
      end
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) begin
        n_total++;
        if (out_result !== exp_r[got] || out_tag !== 5'(got))
          $display("FAIL b2b_result%0d: got %h tag %0d expected %h tag %0d", got, out_result, out_tag, exp_r[got], got);
        else n_pass++;
        $display("b2b retire result=%h tag=%0d", out_result, out_tag);
        got++;
      end
    end
    in_valid = 1'b0;
    n_total++; if (got != 4) $display("FAIL b2b_count: got %0d results expected 4", got); else n_pass++;
    n_total++; if (k != 4) $display("FAIL b2b_accepted: got %0d accepted expected 4", k); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_no_dup: got out_valid %b expected 0", out_valid); else n_pass++;
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_src1   = 32'd5;
    in_src2   = 32'd6;
    in_mode   = 2'b00;
    in_tag    = 5'd10;
    @(negedge clk);
    in_src1 = 32'd7;
    in_tag  = 5'd11;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b expected 1", out_valid); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_async_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (out_tag !== 5'd0) $display("FAIL flush_async_tag: got %0d expected 0", out_tag); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL flush_quiet%0d: got out_valid %b expected 0", i, out_valid); else n_pass++;
    end
    do_op(32'h0000_1234, 32'h0000_0010, 2'b00, 5'd21, res, tg, lat);
    n_total++; if (lat != 3) $display("FAIL flush_new_latency: got %0d expected 3", lat); else n_pass++;
    n_total++;
    if (res !== 32'h0001_2340 || tg !== 5'd21)
      $display("FAIL flush_new_op: got %h tag %0d expected 00012340 tag 21", res, tg);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [63:0] exp_res [4][16];
    logic [4:0]  exp_tag [4][16];
    int          wr [4];
    int          rd [4];
    int          issued [4];
    bit          pending [4];
    bit          all_done;
    int          w;
    logic [63:0] act;
    for (int d = 0; d < 4; d++) begin
      wr[d] = 0; rd[d] = 0; issued[d] = 0; pending[d] = 0;
    end
    all_done = 0;
    for (int cyc = 0; cyc < 3000 && !all_done; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        sw_out_ready[d] = ($urandom_range(0, 3) != 0);
        if (!pending[d] && issued[d] < SW_OPS) begin
          pending[d]     = 1;
          sw_src1[d]     = pick_operand();
          sw_src2[d]     = pick_operand();
          sw_mode[d]     = 2'($urandom_range(0, 3));
          sw_tag[d]      = 5'(issued[d]);
          sw_in_valid[d] = 1'b0;
        end
        sw_in_valid[d] = pending[d] && (sw_in_valid[d] || ($urandom_range(0, 2) != 0));
      end
      #1;
      all_done = 1;
      for (int d = 0; d < 4; d++) begin
        w = (d < 2) ? 16 : 64;
        case (d)
          0:       act = {48'd0, sw_res16[0]};
          1:       act = {48'd0, sw_res16[1]};
          2:       act = sw_res64[0];
          default: act = sw_res64[1];
        endcase
        if (sw_out_valid[d] && sw_out_ready[d]) begin
          n_total++;
          if (rd[d] == wr[d]) begin
            $display("FAIL sweep%0d_spurious: got result %h tag %0d with nothing in flight", d, act, sw_out_tag[d]);
          end else if (act !== exp_res[d][rd[d] % 16] || sw_out_tag[d] !== exp_tag[d][rd[d] % 16]) begin
            $display("FAIL sweep%0d_result: got %h tag %0d expected %h tag %0d", d, act, sw_out_tag[d],
                     exp_res[d][rd[d] % 16], exp_tag[d][rd[d] % 16]);
            rd[d]++;
          end else begin
            n_pass++;
            $display("sweep%0d W%0d retire result=%h tag=%0d", d, w, act, sw_out_tag[d]);
            rd[d]++;
          end
        end
        if (sw_in_valid[d] && sw_in_ready[d]) begin
          exp_res[d][wr[d] % 16] = ref_mul(w, sw_src1[d], sw_src2[d], sw_mode[d]);
          exp_tag[d][wr[d] % 16] = sw_tag[d];
          wr[d]++;
          issued[d]++;
          pending[d] = 0;
        end
        if (issued[d] < SW_OPS || rd[d] != wr[d]) all_done = 0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      sw_in_valid[d]  = 1'b0;
      sw_out_ready[d] = 1'b0;
      n_total++;
      if (rd[d] != SW_OPS) $display("FAIL sweep%0d_count: got %0d results expected %0d", d, rd[d], SW_OPS);
      else n_pass++;
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_latency();
    test_all_ones();
    test_min_neg();
    test_back_to_back();
    test_reset_flush();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
